// File: rtl/mult_fu_if.sv
// Issue / CDB / completion bundle between a MULT reservation station and the
// multiply functional unit. The FU takes the slave view.
interface mult_fu_if #(
   parameter int XLEN          = 32,
   parameter int ROB_TAG_WIDTH = 5,
   parameter int RS_TAG_WIDTH  = 3
);
   logic                     issue_valid;
   logic                     issue_ready;
   logic [XLEN-1:0]          rs1_value;
   logic [XLEN-1:0]          rs2_value;
   logic [1:0]               mult_func;
   logic [ROB_TAG_WIDTH-1:0] rob_tag;
   logic [RS_TAG_WIDTH-1:0]  fu_id;
   logic                     squash;
   logic                     cdb_req;
   logic                     cdb_grant;
   logic [ROB_TAG_WIDTH-1:0] cdb_rob_tag;
   logic [XLEN-1:0]          cdb_value;
   logic                     fu_done;
   logic [RS_TAG_WIDTH-1:0]  fu_done_id;

   modport master (
      output issue_valid, rs1_value, rs2_value, mult_func, rob_tag, fu_id,
             squash, cdb_grant,
      input  issue_ready, cdb_req, cdb_rob_tag, cdb_value, fu_done, fu_done_id
   );

   modport slave (
      input  issue_valid, rs1_value, rs2_value, mult_func, rob_tag, fu_id,
             squash, cdb_grant,
      output issue_ready, cdb_req, cdb_rob_tag, cdb_value, fu_done, fu_done_id
   );
endinterface

// File: rtl/mult_fu.sv
// Iterative RV32M multiply unit: one issue at a time, NUM_STAGES chunk-wise
// partial-product cycles, then holds the result until the CDB grants it.
module mult_fu #(
   parameter int XLEN          = 32,
   parameter int NUM_STAGES    = 4,
   parameter int ROB_TAG_WIDTH = 5,
   parameter int RS_TAG_WIDTH  = 3
) (
   input logic     clock,
   input logic     reset,
   mult_fu_if.slave bus
);
   localparam int DW = 2 * XLEN;
   localparam int W  = DW / NUM_STAGES;
   localparam int CW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, WAIT_CDB} state_t;

   state_t                   state_reg, state_next;
   logic [DW-1:0]            a_shift_reg, b_shift_reg, acc_reg;
   logic [DW-1:0]            a_ext, b_ext, acc_next;
   logic [1:0]               func_reg;
   logic [ROB_TAG_WIDTH-1:0] tag_reg;
   logic [RS_TAG_WIDTH-1:0]  id_reg;
   logic [CW-1:0]            count_reg;
   logic [XLEN-1:0]          cdb_value_reg, result;
   logic                     a_sign, b_sign, last_stage, accept;
   logic                     issue_ready, cdb_req, fu_done;

   // A is signed for everything but MULHU; B is signed only for MUL/MULH.
   assign a_sign = (bus.mult_func != 2'd3) && bus.rs1_value[XLEN-1];
   assign b_sign = !bus.mult_func[1] && bus.rs2_value[XLEN-1];
   assign a_ext  = {{XLEN{a_sign}}, bus.rs1_value};
   assign b_ext  = {{XLEN{b_sign}}, bus.rs2_value};

   // A is pre-shifted and B consumed from its low end, so each cycle adds
   // A * chunk already aligned to its weight.
   assign acc_next   = acc_reg + a_shift_reg * DW'(b_shift_reg[W-1:0]);
   assign result     = (func_reg == 2'd0) ? acc_next[XLEN-1:0] : acc_next[DW-1:XLEN];
   assign last_stage = (count_reg == CW'(NUM_STAGES - 1));

   always_comb begin
      state_next  = state_reg;
      accept      = 1'b0;
      issue_ready = 1'b0;
      cdb_req     = 1'b0;
      fu_done     = 1'b0;
      case (state_reg)
         IDLE: begin
            issue_ready = 1'b1;
            if (bus.issue_valid && !bus.squash) begin
               accept     = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (last_stage) state_next = WAIT_CDB;
         end
         WAIT_CDB: begin
            cdb_req = !bus.squash;
            fu_done = !bus.squash && bus.cdb_grant;
            if (bus.cdb_grant) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (bus.squash) state_next = IDLE;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= IDLE;
         a_shift_reg   <= '0;
         b_shift_reg   <= '0;
         acc_reg       <= '0;
         func_reg      <= '0;
         tag_reg       <= '0;
         id_reg        <= '0;
         count_reg     <= '0;
         cdb_value_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            a_shift_reg <= a_ext;
            b_shift_reg <= b_ext;
            func_reg    <= bus.mult_func;
            tag_reg     <= bus.rob_tag;
            id_reg      <= bus.fu_id;
            acc_reg     <= '0;
            count_reg   <= '0;
         end else if (state_reg == BUSY && !bus.squash) begin
            acc_reg     <= acc_next;
            a_shift_reg <= a_shift_reg << W;
            b_shift_reg <= b_shift_reg >> W;
            count_reg   <= count_reg + 1'b1;
            if (last_stage) cdb_value_reg <= result;
         end
      end
   end

   assign bus.issue_ready = issue_ready;
   assign bus.cdb_req     = cdb_req;
   assign bus.fu_done     = fu_done;
   assign bus.cdb_value   = cdb_value_reg;
   assign bus.cdb_rob_tag = tag_reg;
   assign bus.fu_done_id  = id_reg;
endmodule

// File: tb/tb_mult_fu.sv
// Self-checking bench for mult_fu: directed corner cases plus random operations
// compared against a 64-bit arithmetic reference.
module tb_mult_fu;
   localparam int XLEN = 32;
   localparam int NUM_STAGES = 4;

   logic clock;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   mult_fu_if #(.XLEN(XLEN), .ROB_TAG_WIDTH(5), .RS_TAG_WIDTH(3)) bus ();

   mult_fu #(.XLEN(XLEN), .NUM_STAGES(NUM_STAGES), .ROB_TAG_WIDTH(5), .RS_TAG_WIDTH(3)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] ref_mult(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      case (f)
         2'd0:    p = sa * sb;
         2'd1:    p = sa * sb;
         2'd2:    p = sa * ub;
         default: p = ua * ub;
      endcase
      return (f == 2'd0) ? p[31:0] : p[63:32];
   endfunction

   task automatic drive_op(input logic [1:0] func, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag, input logic [2:0] id);
      bus.issue_valid = 1'b1;
      bus.mult_func   = func;
      bus.rs1_value   = a;
      bus.rs2_value   = b;
      bus.rob_tag     = tag;
      bus.fu_id       = id;
   endtask

   // Issue one op, wait for the broadcast, withhold grant gdelay cycles.
   task automatic run_op(input logic [1:0] func, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [2:0] id, input int gdelay,
                         input logic [31:0] exp, input string name);
      int waited;
      tick();
      drive_op(func, a, b, tag, id);
      bus.cdb_grant = (gdelay == 0);
      #1;
      check({name, "_ready"}, 64'(bus.issue_ready), 64'd1);
      waited = 0;
      do begin
         tick();
         bus.issue_valid = 1'b0;
         #1;
         waited++;
      end while (!bus.cdb_req && waited < 20);
      check({name, "_latency"}, 64'(waited), 64'(NUM_STAGES + 1));
      for (int w = 0; w < gdelay; w++) begin
         check({name, "_stall_req"}, 64'(bus.cdb_req), 64'd1);
         check({name, "_stall_done"}, 64'(bus.fu_done), 64'd0);
         check({name, "_stall_val"}, 64'(bus.cdb_value), 64'(exp));
         check({name, "_stall_tag"}, 64'(bus.cdb_rob_tag), 64'(tag));
         tick();
         bus.issue_valid = (w == 0);
         bus.cdb_grant   = (w == gdelay - 1);
         #1;
         if (w == 0) check({name, "_stall_ready"}, 64'(bus.issue_ready), 64'd0);
      end
      check({name, "_req"}, 64'(bus.cdb_req), 64'd1);
      check({name, "_done"}, 64'(bus.fu_done), 64'd1);
      check({name, "_done_id"}, 64'(bus.fu_done_id), 64'(id));
      check({name, "_val"}, 64'(bus.cdb_value), 64'(exp));
      check({name, "_tag"}, 64'(bus.cdb_rob_tag), 64'(tag));
      $display("op %s func=%0d a=%08h b=%08h tag=%0d id=%0d stall=%0d value=%08h expected=%08h",
               name, func, a, b, tag, id, gdelay, bus.cdb_value, exp);
      tick();
      bus.issue_valid = 1'b0;
      bus.cdb_grant   = 1'b0;
      #1;
      check({name, "_after_done"}, 64'(bus.fu_done), 64'd0);
      check({name, "_after_req"}, 64'(bus.cdb_req), 64'd0);
      check({name, "_after_ready"}, 64'(bus.issue_ready), 64'd1);
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_ready"}, 64'(bus.issue_ready), 64'd1);
      check({name, "_req"}, 64'(bus.cdb_req), 64'd0);
      check({name, "_done"}, 64'(bus.fu_done), 64'd0);
      check({name, "_val"}, 64'(bus.cdb_value), 64'd0);
      check({name, "_tag"}, 64'(bus.cdb_rob_tag), 64'd0);
      check({name, "_done_id"}, 64'(bus.fu_done_id), 64'd0);
   endtask

   initial begin
      int n;
      int seen;
      logic [1:0]  rf;
      logic [31:0] ra, rb;

      reset = 1'b1;
      bus.issue_valid = 1'b0;
      bus.rs1_value   = '0;
      bus.rs2_value   = '0;
      bus.mult_func   = '0;
      bus.rob_tag     = '0;
      bus.fu_id       = '0;
      bus.squash      = 1'b0;
      bus.cdb_grant   = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      #1;
      check_idle_outputs("reset");

      // Basic and high-half vectors
      run_op(2'd0, 32'd7, 32'd6, 5'd3, 3'd5, 0, 32'd42, "mul_basic");
      run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 3'd1, 0, 32'h00000000, "mulh_m1");
      run_op(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 3'd2, 0, 32'hFFFFFFFE, "mulhu_max");
      run_op(2'd2, 32'hFFFFFFFF, 32'd2, 5'd4, 3'd3, 0, 32'hFFFFFFFF, "mulhsu_m1");
      run_op(2'd0, 32'h80000000, 32'd2, 5'd6, 3'd4, 0, 32'h00000000, "mul_wrap");

      // Grant stall with issue pulse while waiting
      run_op(2'd0, 32'd1234, 32'd5678, 5'd9, 3'd6, 3, 32'd7006652, "stall");

      // Squash in BUSY cycle 2 with coincident issue_valid
      tick();
      drive_op(2'd0, 32'd5, 32'd5, 5'd1, 3'd1);
      #1;
      check("sq_busy_accept", 64'(bus.issue_ready), 64'd1);
      tick(); bus.issue_valid = 1'b0; #1;
      tick(); bus.squash = 1'b1; bus.issue_valid = 1'b1; bus.cdb_grant = 1'b1; #1;
      check("sq_busy_req", 64'(bus.cdb_req), 64'd0);
      check("sq_busy_done", 64'(bus.fu_done), 64'd0);
      tick(); bus.squash = 1'b0; bus.issue_valid = 1'b0; #1;
      check("sq_busy_ready", 64'(bus.issue_ready), 64'd1);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick(); #1;
         seen += int'(bus.cdb_req) + int'(bus.fu_done);
      end
      check("sq_busy_quiet", 64'(seen), 64'd0);
      bus.cdb_grant = 1'b0;
      run_op(2'd0, 32'd3, 32'd3, 5'd2, 3'd7, 0, 32'd9, "after_sq_busy");

      // Squash in WAIT_CDB with coincident grant
      tick();
      drive_op(2'd0, 32'd11, 32'd13, 5'd7, 3'd4);
      #1;
      n = 0;
      do begin tick(); bus.issue_valid = 1'b0; #1; n++; end while (!bus.cdb_req && n < 20);
      check("sq_wait_req_seen", 64'(bus.cdb_req), 64'd1);
      tick(); bus.squash = 1'b1; bus.cdb_grant = 1'b1; #1;
      check("sq_wait_req", 64'(bus.cdb_req), 64'd0);
      check("sq_wait_done", 64'(bus.fu_done), 64'd0);
      tick(); bus.squash = 1'b0; bus.cdb_grant = 1'b0; #1;
      check("sq_wait_ready", 64'(bus.issue_ready), 64'd1);
      check("sq_wait_req_after", 64'(bus.cdb_req), 64'd0);
      run_op(2'd0, 32'd3, 32'd3, 5'd8, 3'd2, 1, 32'd9, "after_sq_wait");

      // Reset in cycle 3 of an operation
      tick();
      drive_op(2'd3, 32'hDEADBEEF, 32'h12345678, 5'd15, 3'd6);
      #1;
      tick(); bus.issue_valid = 1'b0; #1;
      tick(); #1;
      tick(); reset = 1'b1; #1;
      tick(); reset = 1'b0; bus.cdb_grant = 1'b1; #1;
      check_idle_outputs("midreset");
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick(); #1;
         seen += int'(bus.cdb_req) + int'(bus.fu_done);
      end
      check("midreset_quiet", 64'(seen), 64'd0);

      // Back-to-back with grant tied high
      tick();
      drive_op(2'd0, 32'd7, 32'd6, 5'd3, 3'd5);
      #1;
      check("b2b_first_ready", 64'(bus.issue_ready), 64'd1);
      tick();
      drive_op(2'd0, 32'd3, 32'd3, 5'd6, 3'd2);
      #1;
      n = 0;
      while (!bus.fu_done && n < 20) begin tick(); #1; n++; end
      check("b2b_first_done", 64'(bus.fu_done), 64'd1);
      check("b2b_first_val", 64'(bus.cdb_value), 64'd42);
      check("b2b_first_tag", 64'(bus.cdb_rob_tag), 64'd3);
      check("b2b_first_id", 64'(bus.fu_done_id), 64'd5);
      $display("op b2b_first value=%08h tag=%0d id=%0d", bus.cdb_value, bus.cdb_rob_tag, bus.fu_done_id);
      tick(); #1;
      check("b2b_second_accept", 64'(bus.issue_ready), 64'd1);
      tick(); bus.issue_valid = 1'b0; #1;
      n = 1;
      while (!bus.fu_done && n < 20) begin tick(); #1; n++; end
      check("b2b_second_latency", 64'(n), 64'(NUM_STAGES + 1));
      check("b2b_second_val", 64'(bus.cdb_value), 64'd9);
      check("b2b_second_tag", 64'(bus.cdb_rob_tag), 64'd6);
      check("b2b_second_id", 64'(bus.fu_done_id), 64'd2);
      $display("op b2b_second value=%08h tag=%0d id=%0d", bus.cdb_value, bus.cdb_rob_tag, bus.fu_done_id);
      tick(); bus.cdb_grant = 1'b0; #1;

      // Random operations against the reference
      for (int i = 0; i < 24; i++) begin
         rf = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       ra = 32'h80000000;
            1:       ra = 32'hFFFFFFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 3))
            0:       rb = 32'h7FFFFFFF;
            1:       rb = 32'hFFFFFFFF;
            default: rb = $urandom;
         endcase
         run_op(rf, ra, rb, 5'($urandom), 3'($urandom), int'($urandom_range(0, 3)),
                ref_mult(rf, ra, rb), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mult_fu.md
Name: mult_fu

Overview:
- Multi-cycle integer multiply functional unit on the execute side of the RS issue interface.
- Accepts one issued instruction from a MULT reservation-station entry and computes the RV32M multiply result iteratively.
- Arbitrates for the CDB to broadcast the result.
- On CDB grant, returns a one-cycle fu_done for the originating RS entry so the RS frees it.
- Single occupancy: not pipelined.

Parameters:
- XLEN, 32, operand/result width.
- NUM_STAGES, 4, iteration cycles. 2*XLEN must be divisible by NUM_STAGES.
- ROB_TAG_WIDTH, 5, ROB tag width.
- RS_TAG_WIDTH, 3, RS entry index width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  RS entry has operands ready and requests issue.
- issue_ready  out  1  FU idle; can accept an issue.
- rs1_value  in  XLEN  operand A.
- rs2_value  in  XLEN  operand B.
- mult_func  in  2  operation: 0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- rob_tag  in  ROB_TAG_WIDTH  destination ROB tag.
- fu_id  in  RS_TAG_WIDTH  issuing RS entry index.
- squash  in  1  branch mispredict flush.
- cdb_req  out  1  result ready, requesting CDB.
- cdb_grant  in  1  CDB arbiter grant for this cycle.
- cdb_rob_tag  out  ROB_TAG_WIDTH  tag broadcast with result.
- cdb_value  out  XLEN  result value.
- fu_done  out  1  one-cycle completion to RS.
- fu_done_id  out  RS_TAG_WIDTH  RS entry being completed.

Behaviour:
- Clock and reset: single clock domain on clock; reset is synchronous, active-high.
- Reset:
  - State=IDLE.
  - Accumulator, latched operands, counter, cdb_value, cdb_rob_tag, fu_done_id all 0.
  - cdb_req=0, fu_done=0, issue_ready=1 in the first cycle after reset deasserts.
  - Reset mid-operation aborts it; no fu_done is ever produced for it.
- States: IDLE, BUSY, WAIT_CDB.
- IDLE:
  - issue_ready=1.
  - If issue_valid && !squash: latch operands, mult_func, rob_tag, fu_id; clear accumulator and counter; go to BUSY.
  - Otherwise stay in IDLE.
- Operand extension to 2*XLEN:
  - MUL, MULH: both operands sign-extended.
  - MULHSU: A sign-extended, B zero-extended.
  - MULHU: both zero-extended.
- BUSY:
  - Each cycle, process the next chunk of W=2*XLEN/NUM_STAGES multiplier bits of B, LSB chunk first.
  - accumulator += (A * chunk) << (W*count), modulo 2^(2*XLEN).
  - count increments each cycle.
  - At the edge where count==NUM_STAGES-1: go to WAIT_CDB and register cdb_value.
    - MUL: cdb_value = product[XLEN-1:0].
    - All others: cdb_value = product[2*XLEN-1:XLEN].
- Latency: issue accepted in cycle t gives cdb_req first high in cycle t+NUM_STAGES+1.
- WAIT_CDB:
  - cdb_req = !squash.
  - cdb_value and cdb_rob_tag are held stable while waiting.
  - fu_done = cdb_req && cdb_grant, combinational, in the same cycle as the broadcast. fu_done_id = latched fu_id.
  - On grant: go to IDLE; issue_ready is high the next cycle.
  - With no grant: remain in WAIT_CDB indefinitely.
- cdb_grant outside WAIT_CDB is ignored.
- issue_ready=0 in BUSY and WAIT_CDB. issue_valid is ignored in those states.
- Squash (any state):
  - Next state IDLE; latched state discarded.
  - cdb_req and fu_done forced 0 in the squash cycle.
  - An issue_valid coincident with squash is not accepted.
  - The RS is responsible for freeing the squashed entry.
- Back-to-back: after a grant in cycle g, the next issue can be accepted in cycle g+1.

Test Plan:
- Basic MUL: MUL 7×6, fu_id=5, rob_tag=3, accepted cycle 0, grant held high. Expect:
  - cdb_req high at cycle 5 with cdb_value=42 and cdb_rob_tag=3.
  - fu_done=1 and fu_done_id=5 in cycle 5.
  - issue_ready=1 in cycle 6.
- High-half variants:
  - MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
  - MUL 0x80000000×2 → 0x00000000.
- Grant stall: grant withheld 3 cycles after cdb_req rises, issue_valid pulsed during the wait. Expect:
  - cdb_value and tag stable throughout.
  - fu_done=0 until the grant cycle.
  - Issue not accepted.
  - Exactly one fu_done pulse.
- Squash in BUSY (cycle 2) and in WAIT_CDB with a coincident grant. Expect:
  - No fu_done, cdb_req=0 that cycle.
  - issue_ready=1 next cycle.
  - A new MUL 3×3 then yields 9.
- Reset mid-operation: reset asserted in cycle 3 of an operation. Expect:
  - All outputs 0 and issue_ready=1 after reset deasserts.
  - No fu_done appears afterward.
- Back-to-back: two issues with grant tied high. Expect:
  - Second accepted the cycle after the first's fu_done.
  - Results 42 then 9 with their respective tags and ids.
